// File: rtl/tap_bank_pkg.sv
// Shared types and default sizes for the tap bank receiver.
package tap_bank_pkg;

    localparam int DEF_NTAPS = 15;
    localparam int DEF_TAP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_READ
    } state_t;

endpackage

// File: rtl/tap_regfile.sv
// Tap storage: NTAPS x TAP_W, one synchronous write port and one registered read port.
module tap_regfile #(
    parameter int NTAPS = 15,
    parameter int TAP_W = 16,
    parameter int AW    = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [TAP_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [TAP_W-1:0] rd_data
);

    logic [TAP_W-1:0] mem [NTAPS];

    // Read data only moves when the controller asks, so it holds during backpressure.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < NTAPS; i++) begin
                mem[i] <= '0;
            end
            rd_data <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_addr] <= wr_data;
            end
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/tap_bank_rx.sv
// Tap bank receiver: loads NTAPS taps, then streams them back with valid/ready.
// Optional running checksum output enabled by defining TAP_BANK_CHECKSUM_EN.
module tap_bank_rx
    import tap_bank_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int TAP_W = DEF_TAP_W
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_tap_wr,
    input  logic [TAP_W-1:0] i_tap,
    input  logic             i_rd_start,
    input  logic             i_rd_ready,
    output logic             o_rd_valid,
    output logic [TAP_W-1:0] o_rd_data,
    output logic [3:0]       o_rd_idx,
    output logic             o_loaded,
    output logic             o_err_short
`ifdef TAP_BANK_CHECKSUM_EN
    ,
    output logic [TAP_W-1:0] o_checksum
`endif
);

    localparam int         AW       = $clog2(NTAPS);
    localparam logic [3:0] LAST_IDX = 4'(NTAPS - 1);

    state_t     state, state_n;
    logic [3:0] wr_ptr, wr_ptr_n;
    logic [3:0] rd_idx, rd_idx_n;
    logic       rd_valid_n, loaded_n, err_short_n;
    logic       wr_en, rd_en;
    logic [3:0] wr_addr, rd_addr;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_idx      <= '0;
            o_rd_valid  <= 1'b0;
            o_loaded    <= 1'b0;
            o_err_short <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            rd_idx      <= rd_idx_n;
            o_rd_valid  <= rd_valid_n;
            o_loaded    <= loaded_n;
            o_err_short <= err_short_n;
        end
    end

    // A tap write outside LOAD always restarts the load, regardless of any readback.
    always_comb begin
        state_n     = state;
        wr_ptr_n    = wr_ptr;
        rd_idx_n    = rd_idx;
        rd_valid_n  = o_rd_valid;
        loaded_n    = o_loaded;
        err_short_n = o_err_short;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr;
        rd_en       = 1'b0;
        rd_addr     = '0;

        if (i_tap_wr && state != ST_LOAD) begin
            wr_en      = 1'b1;
            wr_addr    = '0;
            wr_ptr_n   = 4'd1;
            loaded_n   = 1'b0;
            rd_valid_n = 1'b0;
            state_n    = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE: ;
                ST_LOAD: begin
                    if (i_tap_wr) begin
                        wr_en = 1'b1;
                        if (wr_ptr == LAST_IDX) begin
                            wr_ptr_n    = '0;
                            loaded_n    = 1'b1;
                            err_short_n = 1'b0;
                            state_n     = ST_FULL;
                        end else begin
                            wr_ptr_n = wr_ptr + 4'd1;
                        end
                    end else begin
                        err_short_n = 1'b1;
                        wr_ptr_n    = '0;
                        state_n     = ST_IDLE;
                    end
                end
                ST_FULL: begin
                    if (i_rd_start) begin
                        rd_en      = 1'b1;
                        rd_addr    = '0;
                        rd_idx_n   = '0;
                        rd_valid_n = 1'b1;
                        state_n    = ST_READ;
                    end
                end
                ST_READ: begin
                    // Prefetch the next word on a transfer so back-to-back reads need no bubble.
                    if (o_rd_valid && i_rd_ready) begin
                        if (rd_idx == LAST_IDX) begin
                            rd_valid_n = 1'b0;
                            state_n    = ST_FULL;
                        end else begin
                            rd_idx_n = rd_idx + 4'd1;
                            rd_en    = 1'b1;
                            rd_addr  = rd_idx + 4'd1;
                        end
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end
    end

    assign o_rd_idx = rd_idx;

    tap_regfile #(
        .NTAPS (NTAPS),
        .TAP_W (TAP_W),
        .AW    (AW)
    ) u_regfile (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .wr_en   (wr_en),
        .wr_addr (wr_addr[AW-1:0]),
        .wr_data (i_tap),
        .rd_en   (rd_en),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (o_rd_data)
    );

`ifdef TAP_BANK_CHECKSUM_EN
    logic [TAP_W-1:0] sum_acc;

    // Partial sums live in sum_acc; o_checksum only changes when a load completes.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            sum_acc    <= '0;
            o_checksum <= '0;
        end else if (wr_en) begin
            if (state != ST_LOAD) begin
                sum_acc <= i_tap;
            end else if (wr_ptr == LAST_IDX) begin
                o_checksum <= sum_acc + i_tap;
            end else begin
                sum_acc <= sum_acc + i_tap;
            end
        end
    end
`endif

endmodule

// File: tb/tb_tap_bank_rx.sv
// Self-checking bench for tap_bank_rx; a queue-based model tracks committed and pending loads.
// Checksum checks are compiled in when TAP_BANK_CHECKSUM_EN is defined.
module tb_tap_bank_rx;

    localparam int N = 15;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_tap_wr;
    logic [15:0] i_tap;
    logic        i_rd_start;
    logic        i_rd_ready;
    logic        o_rd_valid;
    logic [15:0] o_rd_data;
    logic [3:0]  o_rd_idx;
    logic        o_loaded;
    logic        o_err_short;
`ifdef TAP_BANK_CHECKSUM_EN
    logic [15:0] o_checksum;
`endif

    int vectors;
    int miscompares;

    logic [15:0] committed[$];
    logic [15:0] pending[$];
    bit          m_loaded;
    bit          m_err;
    logic [15:0] m_cksum;

    always #5 i_clk = ~i_clk;

    tap_bank_rx #(
        .NTAPS (N),
        .TAP_W (16)
    ) dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_tap_wr    (i_tap_wr),
        .i_tap       (i_tap),
        .i_rd_start  (i_rd_start),
        .i_rd_ready  (i_rd_ready),
        .o_rd_valid  (o_rd_valid),
        .o_rd_data   (o_rd_data),
        .o_rd_idx    (o_rd_idx),
        .o_loaded    (o_loaded),
        .o_err_short (o_err_short)
`ifdef TAP_BANK_CHECKSUM_EN
        ,
        .o_checksum  (o_checksum)
`endif
    );

    task automatic applyStimulus(input logic wr, input logic [15:0] tap,
                                 input logic start, input logic ready);
        i_tap_wr   = wr;
        i_tap      = tap;
        i_rd_start = start;
        i_rd_ready = ready;
        @(posedge i_clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Model: a stream of exactly N writes becomes the readable set; anything shorter is an error.
    task automatic writeTap(input logic [15:0] val, input logic start);
        logic [15:0] s;
        applyStimulus(1'b1, val, start, 1'b0);
        pending.push_back(val);
        m_loaded = 1'b0;
        if (pending.size() == N) begin
            s = '0;
            foreach (pending[i]) s = s + pending[i];
            committed = pending;
            pending.delete();
            m_loaded = 1'b1;
            m_err    = 1'b0;
            m_cksum  = s;
        end
    endtask

    task automatic idleCycle();
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        if (pending.size() > 0) begin
            m_err = 1'b1;
            pending.delete();
        end
    endtask

    task automatic checkStatus(input string tag);
        checkOutput({tag, "_loaded"}, 32'(o_loaded), 32'(m_loaded));
        checkOutput({tag, "_err_short"}, 32'(o_err_short), 32'(m_err));
`ifdef TAP_BANK_CHECKSUM_EN
        checkOutput({tag, "_checksum"}, 32'(o_checksum), 32'(m_cksum));
`endif
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rd_valid"}, 32'(o_rd_valid), 0);
        checkOutput({tag, "_rd_data"}, 32'(o_rd_data), 0);
        checkOutput({tag, "_rd_idx"}, 32'(o_rd_idx), 0);
        checkOutput({tag, "_loaded"}, 32'(o_loaded), 0);
        checkOutput({tag, "_err_short"}, 32'(o_err_short), 0);
`ifdef TAP_BANK_CHECKSUM_EN
        checkOutput({tag, "_checksum"}, 32'(o_checksum), 0);
`endif
    endtask

    task automatic doReset(input string tag);
        i_reset = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        committed.delete();
        pending.delete();
        m_loaded = 1'b0;
        m_err    = 1'b0;
        m_cksum  = '0;
        checkAllZero(tag);
        i_reset = 1'b1;
    endtask

    // Consumer-side scoreboard: every valid cycle must present word cnt until it is taken.
    task automatic readBack(input int mode, input int abort_at, input string tag);
        int cnt;
        int cycles;
        bit rdy;
        bit done;
        cnt    = 0;
        cycles = 0;
        done   = 1'b0;
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkOutput({tag, "_valid_start"}, 32'(o_rd_valid), 1);
        while (!done && cnt < N && cycles < 200) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cycles % 4 == 0) || (cycles % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            if (o_rd_valid !== 1'b1) begin
                checkOutput({tag, "_valid_hold"}, 32'(o_rd_valid), 1);
                done = 1'b1;
            end else begin
                checkOutput({tag, "_idx"}, 32'(o_rd_idx), 32'(cnt));
                checkOutput({tag, "_data"}, 32'(o_rd_data), 32'(committed[cnt]));
                if (cnt == abort_at) begin
                    writeTap(16'($urandom), 1'b0);
                    checkOutput({tag, "_abort_valid"}, 32'(o_rd_valid), 0);
                    checkStatus({tag, "_abort"});
                    done = 1'b1;
                end else begin
                    applyStimulus(1'b0, '0, 1'b0, rdy);
                    if (rdy) cnt++;
                    cycles++;
                end
            end
        end
        if (abort_at < 0) begin
            checkOutput({tag, "_words"}, 32'(cnt), 32'(N));
            checkOutput({tag, "_valid_end"}, 32'(o_rd_valid), 0);
            checkStatus({tag, "_end"});
            if (mode == 0) checkOutput({tag, "_cycles"}, 32'(cycles), 32'(N));
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        i_reset     = 1'b0;
        i_tap_wr    = 1'b0;
        i_tap       = '0;
        i_rd_start  = 1'b0;
        i_rd_ready  = 1'b0;
        m_loaded    = 1'b0;
        m_err       = 1'b0;
        m_cksum     = '0;

        doReset("reset");

        for (int k = 1; k <= N; k++) begin
            writeTap(16'(k), 1'b0);
            if (k == N - 1) checkOutput("loaded_early", 32'(o_loaded), 0);
        end
        checkOutput("seq_loaded", 32'(o_loaded), 1);
        checkOutput("seq_err_short", 32'(o_err_short), 0);
        checkStatus("seq");
        idleCycle();

        readBack(0, -1, "rb_ready");
        readBack(1, -1, "rb_toggle");

        for (int k = 0; k < 7; k++) writeTap(16'($urandom), 1'b0);
        idleCycle();
        checkOutput("short_err", 32'(o_err_short), 1);
        checkOutput("short_loaded", 32'(o_loaded), 0);
        checkStatus("short");
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        checkOutput("start_ignored", 32'(o_rd_valid), 0);
        idleCycle();
        checkOutput("start_ignored2", 32'(o_rd_valid), 0);

        for (int k = 0; k < N; k++) writeTap(16'($urandom), 1'b0);
        checkOutput("reload_err_short", 32'(o_err_short), 0);
        checkStatus("reload");
        readBack(2, -1, "rb_random");

        writeTap(16'($urandom), 1'b1);
        checkOutput("wr_wins_valid", 32'(o_rd_valid), 0);
        checkStatus("wr_wins");
        for (int k = 1; k < N; k++) writeTap(16'($urandom), 1'b0);
        checkStatus("wr_wins_load");

        readBack(0, 5, "rb_abort");
        for (int k = 1; k < N; k++) writeTap(16'($urandom), 1'b0);
        checkStatus("post_abort");
        readBack(2, -1, "rb_after_abort");

        for (int k = 0; k < N; k++) writeTap(16'h1111, 1'b0);
        checkStatus("ck_full");
`ifdef TAP_BANK_CHECKSUM_EN
        checkOutput("ck_ffff", 32'(o_checksum), 32'hFFFF);
`endif
        for (int k = 0; k < 3; k++) writeTap(16'($urandom), 1'b0);
        idleCycle();
        checkStatus("ck_aborted");
`ifdef TAP_BANK_CHECKSUM_EN
        checkOutput("ck_kept", 32'(o_checksum), 32'hFFFF);
`endif

        for (int k = 0; k < 4; k++) writeTap(16'($urandom), 1'b0);
        doReset("reset_mid_load");
        for (int k = 0; k < 3; k++) idleCycle();
        checkAllZero("post_reset_load");

        for (int k = 0; k < N; k++) writeTap(16'($urandom), 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        doReset("reset_mid_read");
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkAllZero("post_reset_read");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tap_bank_rx.md
TAP_BANK_RX -- requirements
Module: tap_bank_rx

Interface
REQ-001 SHALL have parameter NTAPS, default 15, number of taps per complete load (2..16).
REQ-002 SHALL have parameter TAP_W, default 16, tap word width.
REQ-003 i_clk  input  1  clock; all logic on rising edge.
REQ-004 i_reset  input  1  reset, synchronous, active-low.
REQ-005 i_tap_wr  input  1  tap write strobe, active high; one tap per cycle.
REQ-006 i_tap  input  TAP_W  tap value, valid when i_tap_wr=1.
REQ-007 i_rd_start  input  1  readback request, single-cycle pulse, active high.
REQ-008 i_rd_ready  input  1  readback consumer ready.
REQ-009 o_rd_valid  output  1  readback word valid.
REQ-010 o_rd_data  output  TAP_W  readback tap value.
REQ-011 o_rd_idx  output  4  index of o_rd_data, 0 = first tap written.
REQ-012 o_loaded  output  1  complete NTAPS-tap set held.
REQ-013 o_err_short  output  1  sticky: load stream ended before NTAPS taps.

Function
REQ-014 SHALL implement states IDLE, LOAD, FULL, READ.
REQ-015 Any state, i_tap_wr=1 while not in LOAD SHALL store i_tap at index 0, set wr_ptr=1, clear o_loaded next cycle, enter LOAD.
REQ-016 LOAD, i_tap_wr=1 SHALL store i_tap at wr_ptr and increment wr_ptr; write of index NTAPS-1 SHALL enter FULL with o_loaded=1 the following cycle.
REQ-017 LOAD, i_tap_wr=0 (gap before NTAPS taps) SHALL set o_err_short, reset wr_ptr to 0, enter IDLE; partial taps are not readable.
REQ-018 FULL, i_rd_start=1 and i_tap_wr=0 SHALL enter READ with o_rd_valid=1, o_rd_idx=0 the next cycle.
REQ-019 i_rd_start outside FULL SHALL be ignored; i_tap_wr wins over i_rd_start in the same cycle.
REQ-020 READ: transfer occurs when o_rd_valid and i_rd_ready both 1; o_rd_data/o_rd_idx SHALL hold stable while o_rd_valid=1 and i_rd_ready=0.
REQ-021 After a transfer, o_rd_idx SHALL advance by 1 with o_rd_valid kept 1 (back-to-back, one word/cycle); transfer of index NTAPS-1 SHALL drop o_rd_valid and return to FULL.
REQ-022 i_tap_wr=1 in READ SHALL abort readback (o_rd_valid=0 next cycle) and start a load per REQ-015.
REQ-023 o_err_short SHALL clear only on reset or on entering FULL.
REQ-024 Stored taps SHALL be written only by i_tap_wr; readback SHALL not modify them.

Reset
REQ-025 On i_reset=0 at a clock edge: state=IDLE, wr_ptr=0, rd index=0, o_rd_valid=0, o_rd_data=0, o_rd_idx=0, o_loaded=0, o_err_short=0, all stored taps=0.
REQ-026 Reset mid-LOAD or mid-READ SHALL discard the transaction with no further output activity.

Configuration
REQ-027 Macro TAP_BANK_CHECKSUM_EN defined: SHALL add output o_checksum (TAP_W), modulo-2^TAP_W sum of the taps of the most recent complete load, updated the cycle o_loaded rises, reset 0, unchanged by aborted loads.
REQ-028 Macro undefined: o_checksum port and its adder SHALL not exist; all other behaviour identical.

Structure
REQ-029 Package tap_bank_pkg SHALL hold the state enum, default NTAPS and TAP_W constants.
REQ-030 Storage SHALL be a sub-module tap_regfile (NTAPS x TAP_W, one synchronous write port, one registered read port); FSM and handshake in tap_bank_rx.

Verification
REQ-031 Reset, then 15 contiguous writes 0x0001..0x000F -> o_loaded=1 one cycle after last write, o_err_short=0.
REQ-032 After REQ-031 load, i_rd_start pulse with i_rd_ready=1 -> 15 consecutive words idx 0..14, data 0x0001..0x000F, then o_rd_valid=0.
REQ-033 Readback with i_rd_ready toggling 1,0,0,1 -> idx 1 data held 2 cycles, no word lost or duplicated.
REQ-034 7 writes then gap -> o_err_short=1, o_loaded=0, subsequent i_rd_start ignored; full reload -> o_err_short=0.
REQ-035 i_tap_wr asserted at idx 5 of readback -> o_rd_valid=0 next cycle, o_loaded=0, new load completes normally; reset during load -> all outputs 0.
REQ-036 With TAP_BANK_CHECKSUM_EN, load 15 x 0x1111 -> o_checksum=0xFFFF; aborted 3-tap load afterwards leaves 0xFFFF.
